// File: rtl/rs232_pkg.sv
// -----------------------------------------------------------------------------
// rs232_pkg
// Shared definitions for the RS232 blocks:
//   - rx_state_t : receiver FSM state encoding
//   - SMP_*      : oversample indices at which the line is sampled for voting
//   - tick_div() : clock divisor for one oversample tick
//   - maj3()     : 2-of-3 majority vote
// -----------------------------------------------------------------------------
package rs232_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } rx_state_t;

    // Three samples around the middle of a 16x oversampled bit; the last one
    // is also the decision point.
    localparam int SMP_FIRST = 7;
    localparam int SMP_MID   = 8;
    localparam int SMP_LAST  = 9;

    // Clocks per oversample tick, truncated (27 for 50 MHz / 115200 / 16).
    function automatic int tick_div(input int f, input int baud, input int ovs);
        return f / (baud * ovs);
    endfunction

    // Majority of three samples.
    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/rs232_rx_if.sv
// -----------------------------------------------------------------------------
// rs232_rx_if
// Line and consumer-side signals of the RS232 receiver.
//   rx         : serial line into the receiver (idle high)
//   rd         : consumer acknowledge, clears data_valid
//   data       : last received byte
//   data_valid : level, byte waiting for the consumer
//   frame_err  : one-clk pulse, stop bit sampled low
//   overrun    : one-clk pulse, byte completed while data_valid was high
//   busy       : receiver is inside a frame
// master = the receiver, slave = line driver / consumer.
// -----------------------------------------------------------------------------
interface rs232_rx_if;
    logic       rx;
    logic       rd;
    logic [7:0] data;
    logic       data_valid;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    modport master (
        input  rx, rd,
        output data, data_valid, frame_err, overrun, busy
    );

    modport slave (
        output rx, rd,
        input  data, data_valid, frame_err, overrun, busy
    );
endinterface

// File: rtl/rs232_baud_tick.sv
// -----------------------------------------------------------------------------
// rs232_baud_tick
// Oversample tick generator: counts 0..TICKDIV-1 while enabled and emits a
// one-clk tick on wrap. Disabled, the counter is held at 0 so that enabling it
// starts a full tick period from a known phase.
//   clk  : system clock
//   rst  : asynchronous reset, active-low
//   en   : run the counter
//   tick : one-clk pulse every TICKDIV clocks while en is high
// -----------------------------------------------------------------------------
module rs232_baud_tick
    import rs232_pkg::*;
#(
    parameter int F          = 50_000_000,
    parameter int BAUDRATE   = 115_200,
    parameter int OVERSAMPLE = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);
    localparam int TICKDIV = tick_div(F, BAUDRATE, OVERSAMPLE);
    localparam int CW      = (TICKDIV > 1) ? $clog2(TICKDIV) : 1;

    logic [CW-1:0] cnt_r;
    logic          tick_r;

    // Divider counter and registered tick pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_r  <= '0;
            tick_r <= 1'b0;
        end else if (!en) begin
            cnt_r  <= '0;
            tick_r <= 1'b0;
        end else if (cnt_r == CW'(TICKDIV - 1)) begin
            cnt_r  <= '0;
            tick_r <= 1'b1;
        end else begin
            cnt_r  <= cnt_r + 1'b1;
            tick_r <= 1'b0;
        end
    end

    assign tick = tick_r;

endmodule

// File: rtl/rs232_rx.sv
// -----------------------------------------------------------------------------
// rs232_rx
// 8N1 serial receiver with 16x oversampling and 3-sample majority voting.
//   clk : system clock (rising edge)
//   rst : asynchronous reset, active-low
//   bus : rs232_rx_if.master -- rx, rd in; data, data_valid, frame_err,
//         overrun, busy out (all outputs registered)
// The stop bit is decided at its sample point and the FSM returns to IDLE
// immediately, so a start bit right after the stop bit is still caught.
// -----------------------------------------------------------------------------
module rs232_rx
    import rs232_pkg::*;
#(
    parameter int F          = 50_000_000,
    parameter int BAUDRATE   = 115_200,
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       rst,
    rs232_rx_if.master bus
);
    localparam int            SW      = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam logic [SW-1:0] S_LAST  = SW'(OVERSAMPLE - 1);
    localparam logic [SW-1:0] S_FIRST = SW'(SMP_FIRST);
    localparam logic [SW-1:0] S_MID   = SW'(SMP_MID);
    localparam logic [SW-1:0] S_DEC   = SW'(SMP_LAST);

    // synchronizer
    logic          rx_meta_r;
    logic          rxs_r;
    // FSM and datapath state
    rx_state_t     state_r,  state_nx;
    logic [SW-1:0] s_r,      s_nx;
    logic [2:0]    n_r,      n_nx;
    logic          smp_a_r,  smp_a_nx;
    logic          smp_b_r,  smp_b_nx;
    logic [7:0]    shift_r,  shift_nx;
    logic [7:0]    data_r,   data_nx;
    logic          dv_r,     dv_nx;
    logic          fe_r,     fe_nx;
    logic          ov_r,     ov_nx;
    logic          busy_r,   busy_nx;
    // combinational helpers
    logic          tick_s;
    logic          maj_s;
    logic          s_wrap_s;
    logic          s_dec_s;
    logic [SW-1:0] s_step_s;

    rs232_baud_tick #(
        .F          (F),
        .BAUDRATE   (BAUDRATE),
        .OVERSAMPLE (OVERSAMPLE)
    ) u_baud_tick (
        .clk  (clk),
        .rst  (rst),
        .en   (busy_r),
        .tick (tick_s)
    );

    // Two-flop synchronizer; resets to the idle (high) line level.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_meta_r <= 1'b1;
            rxs_r     <= 1'b1;
        end else begin
            rx_meta_r <= bus.rx;
            rxs_r     <= rx_meta_r;
        end
    end

    // The third vote is the live sample taken on the decision tick itself.
    assign maj_s    = maj3(smp_a_r, smp_b_r, rxs_r);
    assign s_wrap_s = tick_s && (s_r == S_LAST);
    assign s_dec_s  = tick_s && (s_r == S_DEC);
    assign s_step_s = (s_r == S_LAST) ? '0 : s_r + 1'b1;

    // Next-state, datapath and output computation.
    always_comb begin
        state_nx = state_r;
        s_nx     = tick_s ? s_step_s : s_r;
        n_nx     = n_r;
        smp_a_nx = (tick_s && (s_r == S_FIRST)) ? rxs_r : smp_a_r;
        smp_b_nx = (tick_s && (s_r == S_MID))   ? rxs_r : smp_b_r;
        shift_nx = shift_r;
        data_nx  = data_r;
        // rd clears a pending byte; ignored when nothing is pending.
        dv_nx    = bus.rd ? 1'b0 : dv_r;
        fe_nx    = 1'b0;
        ov_nx    = 1'b0;

        case (state_r)
            ST_IDLE: begin
                s_nx = '0;
                if (!rxs_r) begin
                    state_nx = ST_START;
                end else begin
                    state_nx = ST_IDLE;
                end
            end
            ST_START: begin
                if (s_dec_s && maj_s) begin
                    // start bit did not hold low: glitch, drop silently
                    state_nx = ST_IDLE;
                end else if (s_wrap_s) begin
                    state_nx = ST_DATA;
                    n_nx     = 3'd0;
                end else begin
                    state_nx = ST_START;
                end
            end
            ST_DATA: begin
                // LSB first: after eight right-shifts bit 0 sits in shift_r[0]
                if (s_dec_s) begin
                    shift_nx = {maj_s, shift_r[7:1]};
                end else begin
                    shift_nx = shift_r;
                end
                if (s_wrap_s) begin
                    if (n_r == 3'd7) begin
                        state_nx = ST_STOP;
                    end else begin
                        n_nx = n_r + 3'd1;
                    end
                end else begin
                    state_nx = ST_DATA;
                end
            end
            ST_STOP: begin
                if (s_dec_s) begin
                    data_nx = shift_r;
                    if (maj_s) begin
                        dv_nx    = 1'b1;
                        ov_nx    = dv_r & ~bus.rd;
                        state_nx = ST_IDLE;
                    end else begin
                        fe_nx    = 1'b1;
                        state_nx = ST_BREAK;
                    end
                end else begin
                    state_nx = ST_STOP;
                end
            end
            ST_BREAK: begin
                // no start detection until the line has returned high
                if (rxs_r) begin
                    state_nx = ST_IDLE;
                end else begin
                    state_nx = ST_BREAK;
                end
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase

        busy_nx = (state_nx != ST_IDLE);
    end

    // FSM state, datapath and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
            s_r     <= '0;
            n_r     <= 3'd0;
            smp_a_r <= 1'b1;
            smp_b_r <= 1'b1;
            shift_r <= 8'h00;
            data_r  <= 8'h00;
            dv_r    <= 1'b0;
            fe_r    <= 1'b0;
            ov_r    <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_nx;
            s_r     <= s_nx;
            n_r     <= n_nx;
            smp_a_r <= smp_a_nx;
            smp_b_r <= smp_b_nx;
            shift_r <= shift_nx;
            data_r  <= data_nx;
            dv_r    <= dv_nx;
            fe_r    <= fe_nx;
            ov_r    <= ov_nx;
            busy_r  <= busy_nx;
        end
    end

    assign bus.data       = data_r;
    assign bus.data_valid = dv_r;
    assign bus.frame_err  = fe_r;
    assign bus.overrun    = ov_r;
    assign bus.busy       = busy_r;

endmodule

// File: tb/tb_rs232_rx.sv
// -----------------------------------------------------------------------------
// tb_rs232_rx
// Self-checking bench for rs232_rx at default parameters (50 MHz, 115200 bd).
// A line driver serializes 8N1 frames at the ideal 434-clk bit period; a
// monitor counts frame_err / overrun pulses and data_valid rising edges.
// -----------------------------------------------------------------------------
module tb_rs232_rx;

    localparam int BIT = 434;

    logic clk = 1'b0;
    logic rst = 1'b0;

    rs232_rx_if bus ();

    rs232_rx dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int   total    = 0;
    int   bad      = 0;
    int   fe_cnt   = 0;
    int   ov_cnt   = 0;
    int   rise_cnt = 0;
    logic dv_prev  = 1'b0;

    typedef struct {
        logic [7:0] tx;
        logic       stop_v;
        int         idle_n;
        logic [7:0] exp_data;
        logic       exp_dv;
        int         exp_fe;
        int         exp_ov;
        int         exp_rise;
        logic       do_rd;
    } vec_t;

    vec_t vecs [6];

    // Event monitor, sampled just after each rising edge.
    always begin
        @(posedge clk);
        #1;
        if (bus.frame_err === 1'b1) fe_cnt++;
        if (bus.overrun === 1'b1) ov_cnt++;
        if (bus.data_valid === 1'b1 && dv_prev !== 1'b1) rise_cnt++;
        dv_prev = bus.data_valid;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Each waited clock also ends any rd pulse, so rd is always one clk wide.
    task automatic wait_clk(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus.rd = 1'b0;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_v, input int idle_n);
        bus.rx = 1'b0;
        wait_clk(BIT);
        for (int i = 0; i < 8; i++) begin
            bus.rx = b[i];
            wait_clk(BIT);
        end
        bus.rx = stop_v;
        wait_clk(BIT);
        bus.rx = 1'b1;
        wait_clk(idle_n);
    endtask

    initial begin
        //            tx     stop  idle  data   dv    fe ov rise rd
        vecs[0] = '{8'h55, 1'b1, 0,   8'h55, 1'b1, 0, 0, 2, 1'b1};
        vecs[1] = '{8'hAA, 1'b1, 0,   8'hAA, 1'b1, 0, 0, 3, 1'b1};
        vecs[2] = '{8'hA5, 1'b0, BIT, 8'hA5, 1'b0, 1, 0, 3, 1'b0};
        vecs[3] = '{8'h3C, 1'b1, 0,   8'h3C, 1'b1, 1, 0, 4, 1'b1};
        vecs[4] = '{8'h11, 1'b1, 0,   8'h11, 1'b1, 1, 0, 5, 1'b0};
        vecs[5] = '{8'h22, 1'b1, 0,   8'h22, 1'b1, 1, 1, 5, 1'b0};

        bus.rx = 1'b1;
        bus.rd = 1'b0;
        rst    = 1'b0;
        wait_clk(5);

        // reset state
        chk("rst_data", 32'(bus.data), 32'h00);
        chk("rst_dv",   32'(bus.data_valid), 32'h0);
        chk("rst_fe",   32'(bus.frame_err), 32'h0);
        chk("rst_ov",   32'(bus.overrun), 32'h0);
        chk("rst_busy", 32'(bus.busy), 32'h0);
        rst = 1'b1;
        wait_clk(20);

        // single byte, then rd clears data_valid on the next clock
        send_byte(8'h41, 1'b1, 0);
        chk("b41_data", 32'(bus.data), 32'h41);
        chk("b41_dv",   32'(bus.data_valid), 32'h1);
        chk("b41_fe",   32'(fe_cnt), 32'd0);
        chk("b41_rise", 32'(rise_cnt), 32'd1);
        bus.rd = 1'b1;
        wait_clk(1);
        chk("b41_rd_clear", 32'(bus.data_valid), 32'h0);
        wait_clk(BIT);

        // 100-clk (2 us) glitch from idle
        bus.rx = 1'b0;
        wait_clk(50);
        chk("glitch_busy_hi", 32'(bus.busy), 32'h1);
        wait_clk(50);
        bus.rx = 1'b1;
        wait_clk(400);
        chk("glitch_busy_lo", 32'(bus.busy), 32'h0);
        chk("glitch_rise",    32'(rise_cnt), 32'd1);
        chk("glitch_fe",      32'(fe_cnt), 32'd0);
        chk("glitch_data",    32'(bus.data), 32'h41);

        // table: back-to-back, framing error + recovery, overrun
        for (int v = 0; v < 6; v++) begin
            send_byte(vecs[v].tx, vecs[v].stop_v, vecs[v].idle_n);
            chk($sformatf("vec%0d_data", v), 32'(bus.data), 32'(vecs[v].exp_data));
            chk($sformatf("vec%0d_dv", v),   32'(bus.data_valid), 32'(vecs[v].exp_dv));
            chk($sformatf("vec%0d_fe", v),   32'(fe_cnt), 32'(vecs[v].exp_fe));
            chk($sformatf("vec%0d_ov", v),   32'(ov_cnt), 32'(vecs[v].exp_ov));
            chk($sformatf("vec%0d_rise", v), 32'(rise_cnt), 32'(vecs[v].exp_rise));
            bus.rd = vecs[v].do_rd;
        end

        // reset during bit 3 of 8'hF0 (data_valid still set from 8'h22)
        bus.rx = 1'b0;
        wait_clk(BIT);
        wait_clk(3 * BIT);
        wait_clk(200);
        rst    = 1'b0;
        bus.rx = 1'b1;
        wait_clk(1);
        chk("abort_rst_data", 32'(bus.data), 32'h00);
        chk("abort_rst_dv",   32'(bus.data_valid), 32'h0);
        chk("abort_rst_busy", 32'(bus.busy), 32'h0);
        wait_clk(49);
        rst = 1'b1;
        wait_clk(100);
        chk("abort_busy", 32'(bus.busy), 32'h0);
        chk("abort_rise", 32'(rise_cnt), 32'd5);
        chk("abort_fe",   32'(fe_cnt), 32'd1);

        send_byte(8'h0F, 1'b1, 0);
        chk("b0f_data", 32'(bus.data), 32'h0F);
        chk("b0f_dv",   32'(bus.data_valid), 32'h1);
        chk("b0f_rise", 32'(rise_cnt), 32'd6);
        chk("b0f_fe",   32'(fe_cnt), 32'd1);
        chk("b0f_ov",   32'(ov_cnt), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rs232_rx.md
Name: rs232_rx

Overview:
- Synthesizable RS232 (8N1) receiver for the Spartan-3 designs.
- Deserializes the asynchronous rx line into bytes using 16x oversampling and 3-sample majority voting.
- Presents each byte through a valid/read handshake, with framing-error and overrun flags.
- It is the DUT-side counterpart of the team's behavioural RS232 model, which drives its tx line into this block's rx input.

Parameters:
- F, 50_000_000: system clock frequency in Hz.
- BAUDRATE, 115_200: line rate in bit/s.
- OVERSAMPLE, 16: sample ticks per bit period.
- Derived localparam TICKDIV = F/(BAUDRATE*OVERSAMPLE), integer-truncated; 27 with the defaults.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  asynchronous reset, active-low.
- rx  in  1  serial line; idle high; asynchronous to clk.
- rd  in  1  consumer acknowledge; clears data_valid.
- data  out  8  last received byte.
- data_valid  out  1  level; high from byte completion until rd.
- frame_err  out  1  one-clk pulse; stop bit sampled low.
- overrun  out  1  one-clk pulse; a byte completed while data_valid was still high.
- busy  out  1  high while the FSM is not IDLE.

Behaviour:
- Reset (rst low, asynchronous):
  - data=0, data_valid=0, frame_err=0, overrun=0, busy=0.
  - Synchronizer flops=1, FSM=IDLE, counters=0.
  - Reset mid-frame abandons the frame; no flag is raised.
- Input path: 2-flop synchronizer on rx. All decisions use the synchronized value rxs, which lags rx by 2 clk.
- Tick generator:
  - Counts 0..TICKDIV-1 and emits a one-clk tick at wrap.
  - Held at 0 in IDLE; restarts from 0 on the start-edge detect.
- Sample counter s: 0..OVERSAMPLE-1, increments on tick, wraps per bit. Samples are taken at s=7, 8 and 9; the bit value is the majority of the three.
- FSM states: IDLE, START, DATA, STOP, BREAK.
  - IDLE: when rxs=0, go to START; s=0; busy=1.
  - START: at s=9, if majority=1 (glitch), return to IDLE with no flags; otherwise stay until s wraps, then go to DATA with bit index n=0.
  - DATA: 8 bits, LSB first; the majority is shifted into data bit n. After bit 7 wraps, go to STOP.
  - STOP: decision at s=9 on the stop majority; the FSM does not wait for the end of the stop bit.
    - majority=1: load data, set data_valid, go to IDLE.
    - majority=0: load data, pulse frame_err, leave data_valid unchanged, go to BREAK.
  - BREAK: wait for rxs=1, then go to IDLE. No new start is detected while the line is held low.
- Latency: data_valid rises 1 clk after the s=9 tick of the stop bit, about 9.5 bit periods plus 2 clk after the rx falling edge.
- Handshake and overrun:
  - rd while data_valid=1 clears data_valid next clk. rd while data_valid=0 is ignored.
  - Completion with data_valid=1 and rd=0: pulse overrun, overwrite data, data_valid stays 1.
  - Completion and rd in the same clk: no overrun; new data loaded; data_valid stays 1.
- Back-to-back frames: a start bit immediately after the stop decision is accepted, because IDLE is entered mid-stop-bit.
- Clock error: default divisor gives a 432-clk bit period against 434.03 ideal (-0.47%), within the ±5% tolerance the behavioural model checks.

Decomposition:
- Package rs232_pkg holds:
  - FSM state encoding.
  - The TICKDIV derivation function.
  - OVERSAMPLE sample-point constants (7/8/9).
- Sub-module rs232_baud_tick:
  - Parameters F, BAUDRATE, OVERSAMPLE.
  - Ports clk, rst, en, tick.
  - Reusable by the future rs232_tx.
- rs232_rx instantiates rs232_baud_tick with en=busy.

Test Plan:
- Behavioural model transmit(8'h41) → one data_valid with data=8'h41, frame_err=0; rd then clears data_valid next clk.
- Back-to-back transmit 8'h55 then 8'hAA with rd after each → two valids with data 8'h55 then 8'hAA; overrun never pulses.
- 2 µs low glitch on rx from idle → FSM returns to IDLE at start-bit s=9; no data_valid, no frame_err, busy low afterwards.
- Frame 8'hA5 with stop bit forced low for 1 bit period then high → frame_err single pulse, data=8'hA5, data_valid stays 0; a following 8'h3C is received correctly.
- Transmit 8'h11 then 8'h22 without rd → overrun pulses once at the second completion, data=8'h22, data_valid=1.
- rst low during bit 3 of 8'hF0, released 1 µs later, then transmit 8'h0F → no output from the aborted frame; data=8'h0F, data_valid=1.
